// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode and arbiter state encodings for alu_arbiter and its picker.
package alu_arbiter_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_grant_i,
// wrapping modulo NUM_REQ. Reusable for any shared resource.
module alu_arbiter_rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_valid_o
);

    int   hi_idx;
    int   lo_idx;
    int   sel_idx;
    logic hi_found;

    // Descending scan leaves the lowest set index of each region; the region
    // above last_grant_i has priority over the wrapped-around region.
    always_comb begin
        hi_idx   = 0;
        lo_idx   = 0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i > int'(last_grant_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = i;
                end else begin
                    lo_idx = i;
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_o[i] = req_i[i] && (i == sel_idx);
        end
    end

    assign grant_idx_o = sel_idx[ID_W-1:0];
    assign any_valid_o = |req_i;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between NUM_REQ requesters.
// Optional ALU_ARB_STATS_EN adds saturating per-requester grant and busy counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_opcode,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_opcode,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_carry,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_out,
    output logic                      rsp_carry,
    output logic                      rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants,
    output logic [15:0]               stat_busy
`endif
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     last_grant_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [2:0]          alu_opcode_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_out_q;
    logic                rsp_carry_q, rsp_zero_q;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic                grant_en;

    alu_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_oh),
        .grant_idx_o  (pick_idx),
        .any_valid_o  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_any) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_RESP == state_q ? ST_IDLE : state_q;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are masked during reset so no requester sees an accept that reset discards.
    always_comb begin
        grant_en  = (state_q == ST_IDLE) && pick_any && !rst;
        req_ready = grant_en ? pick_oh : '0;
        rsp_valid = (state_q == ST_RESP);
    end

    // last_grant_q doubles as the owner ID of the single outstanding operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            rsp_id_q     <= '0;
            rsp_out_q    <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            if (grant_en) begin
                alu_a_q      <= req_a[int'(pick_idx)*DATA_W +: DATA_W];
                alu_b_q      <= req_b[int'(pick_idx)*DATA_W +: DATA_W];
                alu_opcode_q <= req_opcode[int'(pick_idx)*3 +: 3];
                last_grant_q <= pick_idx;
            end
            if (state_q == ST_EXEC) begin
                rsp_out_q   <= alu_out;
                rsp_carry_q <= alu_carry;
                rsp_zero_q  <= alu_zero;
                rsp_id_q    <= last_grant_q;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] grants_q [NUM_REQ];
    logic [STAT_W-1:0] busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) grants_q[i] <= sat_inc(grants_q[i]);
            end
            if ((|req_valid) && (state_q != ST_IDLE)) busy_q <= sat_inc(busy_q);
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_pack
        assign stat_grants[gi*16 +: 16] = grants_q[gi];
    end
    assign stat_busy = busy_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin reference model.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
    logic [NUM_REQ*3-1:0]      req_opcode;
    logic [DATA_W-1:0]         alu_a, alu_b, alu_out;
    logic [2:0]                alu_opcode;
    logic                      alu_carry, alu_zero;
    logic                      rsp_valid, rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_out;
    logic                      rsp_carry, rsp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     stat_grants;
    logic [15:0]               stat_busy;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_busy(stat_busy)
`endif
    );

    // External 8-bit ALU: {carry, result}
    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {(a < b), 8'(a - b)};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            3'b101:  return {1'b0, ~a};
            3'b110:  return {a[7], 8'(a << 1)};
            default: return {a[0], 8'(a >> 1)};
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);
    assign alu_zero = (alu_out == 8'h00);

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_valid[i]          = v;
        req_a[i*8 +: 8]       = a;
        req_b[i*8 +: 8]       = b;
        req_opcode[i*3 +: 3]  = op;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'h12, 8'h34, 3'b011);
        set_req(1, 1'b1, 8'h56, 8'h78, 3'b100);
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        rst = 1'b0; req_valid = '0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({rsp_out, rsp_carry, rsp_zero, rsp_id} !== 11'h0) begin failures++; $display("FAIL rst_rsp_fields got=%h exp=0", {rsp_out, rsp_carry, rsp_zero, rsp_id}); end
        checks++; if ({alu_a, alu_b, alu_opcode} !== 19'h0) begin failures++; $display("FAIL rst_alu_regs got=%h exp=0", {alu_a, alu_b, alu_opcode}); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_idle_ready got=%b exp=00", req_ready); end
    endtask

    task automatic test_single();
        apply_reset();
        set_req(0, 1'b1, 8'h80, 8'h80, 3'b000); rsp_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_exec_valid got=%b exp=0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_opcode} !== {8'h80, 8'h80, 3'b000}) begin failures++; $display("FAIL single_alu_ops got=%h exp=%h", {alu_a, alu_b, alu_opcode}, {8'h80, 8'h80, 3'b000}); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if ({rsp_out, rsp_carry, rsp_zero, rsp_id} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin failures++; $display("FAIL single_rsp got=%h exp=%h", {rsp_out, rsp_carry, rsp_zero, rsp_id}, {8'h00, 1'b1, 1'b1, 1'b0}); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_alternate();
        int exp_g;
        int owner;
        logic [1:0] exp_ready;
        apply_reset();
        set_req(0, 1'b1, 8'h05, 8'h03, 3'b001);
        set_req(1, 1'b1, 8'hFF, 8'h0F, 3'b100);
        rsp_ready = 1'b1; exp_g = 0; owner = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_ready = (c % 3 == 0) ? 2'(1 << exp_g) : 2'b00;
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL alt_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            if (c % 3 == 2) begin
                checks++; if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 1'(owner), (owner == 0) ? 8'h02 : 8'hF0})
                    begin failures++; $display("FAIL alt_rsp c=%0d got=%h exp=%h", c, {rsp_valid, rsp_id, rsp_out}, {1'b1, 1'(owner), (owner == 0) ? 8'h02 : 8'hF0}); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL alt_idle_valid c=%0d got=%b exp=0", c, rsp_valid); end
            end
            if (c % 3 == 0) begin owner = exp_g; exp_g = 1 - exp_g; end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_req(0, 1'b1, 8'h01, 8'h02, 3'b000);
        set_req(1, 1'b1, 8'hF0, 8'h3C, 3'b010);
        rsp_ready = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant0 got=%b exp=01", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0; #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_exec_ready got=%b exp=00", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if ({rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_id, req_ready} !== {1'b1, 8'h03, 3'b000, 2'b00})
                begin failures++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, {rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_id, req_ready}, {1'b1, 8'h03, 3'b000, 2'b00}); end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        checks++; if ({rsp_valid, req_ready} !== 3'b100) begin failures++; $display("FAIL bp_handshake got=%b exp=100", {rsp_valid, req_ready}); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, req_ready} !== 3'b010) begin failures++; $display("FAIL bp_grant1 got=%b exp=010", {rsp_valid, req_ready}); end
    endtask

    task automatic test_reset_exec();
        apply_reset();
        set_req(0, 1'b1, 8'h81, 8'h00, 3'b110); rsp_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rx_grant got=%b exp=01", req_ready); end
        @(negedge clk);
        set_req(0, 1'b1, 8'h11, 8'h22, 3'b000);
        set_req(1, 1'b1, 8'h33, 8'h44, 3'b011);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rx_abandon got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rx_first_winner got=%b exp=01", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0; #1;
        checks++; if ({rsp_valid, alu_a} !== {1'b0, 8'h11}) begin failures++; $display("FAIL rx_exec got=%h exp=%h", {rsp_valid, alu_a}, {1'b0, 8'h11}); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_carry} !== {1'b1, 1'b0, 8'h33, 1'b0}) begin failures++; $display("FAIL rx_new_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_out, rsp_carry}, {1'b1, 1'b0, 8'h33, 1'b0}); end
    endtask

    task automatic test_drop_valid();
        apply_reset();
        set_req(0, 1'b1, 8'h10, 8'h20, 3'b000); rsp_ready = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL drop_grant0 got=%b exp=01", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0; set_req(1, 1'b1, 8'h0A, 8'h0B, 3'b011); #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL drop_exec got=%b exp=00", req_ready); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, req_ready} !== 3'b100) begin failures++; $display("FAIL drop_resp got=%b exp=100", {rsp_valid, req_ready}); end
        @(negedge clk); req_valid[1] = 1'b0; rsp_ready = 1'b1; #1;
        checks++; if ({rsp_valid, rsp_out, req_ready} !== {1'b1, 8'h30, 2'b00}) begin failures++; $display("FAIL drop_hs got=%h exp=%h", {rsp_valid, rsp_out, req_ready}, {1'b1, 8'h30, 2'b00}); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++; if ({rsp_valid, req_ready} !== 3'b000) begin failures++; $display("FAIL drop_no_grant c=%0d got=%b exp=000", c, {rsp_valid, req_ready}); end
        end
        set_req(0, 1'b1, 8'h01, 8'h01, 3'b000); #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL drop_idle_again got=%b exp=01", req_ready); end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_random();
        int         last;
        int         age;
        int         owner;
        int         win;
        int         busy_cnt;
        int         gcount[NUM_REQ];
        bit         outstanding;
        logic [8:0] exp_r;
        logic [1:0] exp_ready;
        apply_reset();
        last = NUM_REQ - 1; age = 0; owner = 0; outstanding = 1'b0; busy_cnt = 0; exp_r = '0;
        for (int i = 0; i < NUM_REQ; i++) gcount[i] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
                else if (req_valid[i] && $urandom_range(0, 9) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            win = -1;
            exp_ready = '0;
            if (!outstanding) begin
                for (int k = 1; k <= NUM_REQ; k++)
                    if (win < 0 && req_valid[(last + k) % NUM_REQ]) win = (last + k) % NUM_REQ;
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            checks++; if (rsp_valid !== (outstanding && age >= 2)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (outstanding && age >= 2)); end
            if (outstanding && age >= 2) begin
                checks++; if ({rsp_id, rsp_carry, rsp_out, rsp_zero} !== {1'(owner), exp_r, (exp_r[7:0] == 8'h00)})
                    begin failures++; $display("FAIL rnd_rsp cyc=%0d got=%h exp=%h", cyc, {rsp_id, rsp_carry, rsp_out, rsp_zero}, {1'(owner), exp_r, (exp_r[7:0] == 8'h00)}); end
            end
            if ((|req_valid) && outstanding) busy_cnt++;
            if (outstanding && age >= 2 && rsp_ready) outstanding = 1'b0;
            else if (outstanding) age++;
            if (win >= 0) begin
                gcount[win]++;
                outstanding = 1'b1; age = 1; owner = win; last = win;
                exp_r = alu_fn(req_opcode[win*3 +: 3], req_a[win*8 +: 8], req_b[win*8 +: 8]);
            end
            @(negedge clk);
            if (win >= 0) req_valid[win] = 1'b0;
        end
`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++; if (stat_grants[i*16 +: 16] !== 16'(gcount[i])) begin failures++; $display("FAIL stat_grants%0d got=%0d exp=%0d", i, stat_grants[i*16 +: 16], gcount[i]); end
        end
        checks++; if (stat_busy !== 16'(busy_cnt)) begin failures++; $display("FAIL stat_busy got=%0d exp=%0d", stat_busy, busy_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0; rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_reset_exec();
        test_drop_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
